jam_search_n: RTL and testbench

Parametrised exhaustive job-assignment search engine. Generalises the fixed 8x8 worker/job solver to N workers and N jobs, with configurable cost width. Adds a Start/Busy handshake, a reported best assignment and a saturating match counter. It steps through all N! permutations in lexicographic order. For each permutation it reads N costs from an external cost table and reports the minimum total cost, how many permutations achieve it, and the first permutation that achieves it.

---
 rtl/jam_pkg.sv | 26 ++
 rtl/jam_next_perm.sv | 56 +++++
 rtl/jam_search_n.sv | 159 +++++++++++++++
 tb/tb_jam_search_n.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared types for the exhaustive job-assignment search: FSM states and the
// permutation container sized for the largest legal N (8).
package jam_pkg;

    localparam int MAX_N     = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    // Entry k holds the job assigned to worker k; only entries 0..N-1 are meaningful.
    typedef logic [MAX_N-1:0][MAX_IDX_W-1:0] perm_t;

    function automatic perm_t identity_perm();
        perm_t r;
        for (int i = 0; i < MAX_N; i++) begin
            r[i] = MAX_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of an N-entry permutation;
// has_next is low when the input is already the last permutation.
import jam_pkg::*;

module jam_next_perm #(
    parameter int N = 8
) (
    input  perm_t perm,
    output perm_t next_perm,
    output logic  has_next
);

    int                   piv_s;
    int                   succ_s;
    logic [MAX_IDX_W-1:0] pv_s;
    logic [MAX_IDX_W-1:0] sv_s;
    perm_t                tmp_s;

    // Locate pivot and successor, swap them, then reverse the tail after the pivot.
    always_comb begin
        piv_s    = 0;
        has_next = 1'b0;
        pv_s     = perm[0];
        for (int i = 0; i < N - 1; i++) begin
            if (perm[i] < perm[i+1]) begin
                piv_s    = i;
                has_next = 1'b1;
                pv_s     = perm[i];
            end else begin
                piv_s    = piv_s;
            end
        end

        succ_s = piv_s;
        sv_s   = pv_s;
        for (int m = 1; m < N; m++) begin
            if ((m > piv_s) && (perm[m] > pv_s)) begin
                succ_s = m;
                sv_s   = perm[m];
            end else begin
                succ_s = succ_s;
            end
        end

        tmp_s = perm;
        for (int m = 0; m < N; m++) begin
            tmp_s[m] = (m == piv_s) ? sv_s : ((m == succ_s) ? pv_s : perm[m]);
        end

        next_perm = tmp_s;
        for (int m = 0; m < N; m++) begin
            next_perm[m] = (m > piv_s) ? tmp_s[MAX_IDX_W'(N + piv_s - m)] : tmp_s[m];
        end
    end

endmodule

// File: rtl/jam_search_n.sv
// Exhaustive N x N job-assignment search over all N! permutations.
// Optional JAM_EARLY_ABORT_EN skips the rest of a permutation once its partial sum exceeds the best.
import jam_pkg::*;

module jam_search_n #(
    parameter  int N      = 8,
    parameter  int COST_W = 7,
    parameter  int CNT_W  = 16,
    localparam int IDX_W  = ($clog2(N) < 1) ? 1 : $clog2(N),
    localparam int SUM_W  = COST_W + $clog2(N) + 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start,
    output logic               Busy,
    output logic [IDX_W-1:0]   W,
    output logic [IDX_W-1:0]   J,
    input  logic [COST_W-1:0]  Cost,
    output logic [SUM_W-1:0]   MinCost,
    output logic [CNT_W-1:0]   MatchCount,
    output logic [N*IDX_W-1:0] BestPerm,
    output logic               Valid
);

    state_t           state_r, state_nxt_s;
    logic [IDX_W-1:0] k_r, k_nxt_s;
    perm_t            p_r, p_nxt_s, np_s;
    logic             has_next_s;
    logic [SUM_W-1:0] acc_r, acc_s, min_r, cmp_sum_r;
    perm_t            cmp_perm_r, best_r;
    logic             cmp_pend_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r, valid_r;
    logic [IDX_W-1:0] w_r, j_r;
    logic             last_k_s, abort_s, perm_end_s, accept_s;

    jam_next_perm #(.N(N)) u_next (
        .perm      (p_r),
        .next_perm (np_s),
        .has_next  (has_next_s)
    );

    assign acc_s      = acc_r + SUM_W'(Cost);
    assign last_k_s   = (k_r == IDX_W'(N - 1));
    assign accept_s   = (state_r == IDLE) && Start;
    assign perm_end_s = (state_r == READ) && (last_k_s || abort_s);

`ifdef JAM_EARLY_ABORT_EN
    logic [SUM_W-1:0] min_eff_s;
    // A compare still in flight may lower the bound this cycle, so abort against that value.
    assign min_eff_s = (cmp_pend_r && (cmp_sum_r < min_r)) ? cmp_sum_r : min_r;
    assign abort_s   = (state_r == READ) && !last_k_s && (acc_s > min_eff_s);
`else
    assign abort_s   = 1'b0;
`endif

    // Next-state, worker index and permutation stepping.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        p_nxt_s     = p_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    state_nxt_s = READ;
                    k_nxt_s     = {IDX_W{1'b0}};
                    p_nxt_s     = identity_perm();
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (perm_end_s) begin
                    k_nxt_s = {IDX_W{1'b0}};
                    if (has_next_s) begin
                        p_nxt_s     = np_s;
                        state_nxt_s = READ;
                    end else begin
                        state_nxt_s = LAST;
                    end
                end else begin
                    k_nxt_s = k_r + IDX_W'(1);
                end
            end
            LAST:    state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, search position and registered handshake / table-address outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            k_r     <= {IDX_W{1'b0}};
            p_r     <= identity_perm();
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            w_r     <= {IDX_W{1'b0}};
            j_r     <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            k_r     <= k_nxt_s;
            p_r     <= p_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            valid_r <= (state_nxt_s == DONE);
            w_r     <= (state_nxt_s == READ) ? k_nxt_s : {IDX_W{1'b0}};
            j_r     <= (state_nxt_s == READ) ? p_nxt_s[MAX_IDX_W'(k_nxt_s)][IDX_W-1:0]
                                             : {IDX_W{1'b0}};
        end
    end

    // Running sum plus the compare of the previous permutation, overlapped with new reads.
    always_ff @(posedge CLK) begin
        if (RST || accept_s) begin
            acc_r      <= {SUM_W{1'b0}};
            cmp_pend_r <= 1'b0;
            cmp_sum_r  <= {SUM_W{1'b0}};
            cmp_perm_r <= identity_perm();
            min_r      <= {SUM_W{1'b1}};
            cnt_r      <= {CNT_W{1'b0}};
            best_r     <= identity_perm();
        end else begin
            if (cmp_pend_r) begin
                if (cmp_sum_r < min_r) begin
                    min_r  <= cmp_sum_r;
                    cnt_r  <= CNT_W'(1);
                    best_r <= cmp_perm_r;
                end else if ((cmp_sum_r == min_r) && (cnt_r != {CNT_W{1'b1}})) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                min_r <= min_r;
            end
            if (state_r == READ) begin
                acc_r <= perm_end_s ? {SUM_W{1'b0}} : acc_s;
            end else begin
                acc_r <= {SUM_W{1'b0}};
            end
            cmp_pend_r <= (state_r == READ) && last_k_s;
            cmp_sum_r  <= acc_s;
            cmp_perm_r <= p_r;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_best
        assign BestPerm[g*IDX_W +: IDX_W] = best_r[g][IDX_W-1:0];
    end

    assign Busy       = busy_r;
    assign Valid      = valid_r;
    assign W          = w_r;
    assign J          = j_r;
    assign MinCost    = min_r;
    assign MatchCount = cnt_r;

endmodule

// File: tb/tb_jam_search_n.sv
// Directed bench for jam_search_n at N=4 with a 4-bit match counter so saturation is reachable.
module tb_jam_search_n;

    localparam int N        = 4;
    localparam int COST_W   = 7;
    localparam int CNT_W    = 4;
    localparam int IDX_W    = 2;
    localparam int SUM_W    = 10;
    localparam int FULL_LAT = 98;

    logic                 clk = 1'b0;
    logic                 rst, start;
    logic                 busy, valid;
    logic [IDX_W-1:0]     w, j;
    logic [COST_W-1:0]    cost;
    logic [SUM_W-1:0]     min_cost;
    logic [CNT_W-1:0]     match_count;
    logic [N*IDX_W-1:0]   best_perm;
    logic [COST_W-1:0]    cm [4][4];

    always #5 clk = ~clk;
    assign cost = cm[w][j];

    jam_search_n #(.N(N), .COST_W(COST_W), .CNT_W(CNT_W)) u_dut (
        .CLK        (clk),
        .RST        (rst),
        .Start      (start),
        .Busy       (busy),
        .W          (w),
        .J          (j),
        .Cost       (cost),
        .MinCost    (min_cost),
        .MatchCount (match_count),
        .BestPerm   (best_perm),
        .Valid      (valid)
    );

    typedef struct packed {
        logic [15:0][COST_W-1:0] c;
        logic [SUM_W-1:0]        mn;
        logic [CNT_W-1:0]        cnt;
        logic [N*IDX_W-1:0]      best;
    } vec_t;

    vec_t vecs [6];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_lat(input string name, input int lat);
`ifdef JAM_EARLY_ABORT_EN
        check(name, 32'((lat > 0) && (lat <= FULL_LAT)), 32'd1);
`else
        check(name, lat, FULL_LAT);
`endif
    endtask

    task automatic load(input int idx);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                cm[a][b] = vecs[idx].c[a*4+b];
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge of the Valid cycle.
    task automatic wait_valid(inout int lat);
        while ((valid !== 1'b1) && (lat < 300)) begin
            @(negedge clk);
            lat++;
        end
        if (valid !== 1'b1) lat = -1;
    endtask

    task automatic do_run(output int lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        wait_valid(lat);
    endtask

    task automatic check_result(input string tag, input int idx, input int lat);
        check_lat({tag, "_lat"}, lat);
        check({tag, "_min"}, min_cost, vecs[idx].mn);
        check({tag, "_cnt"}, match_count, vecs[idx].cnt);
        check({tag, "_best"}, best_perm, vecs[idx].best);
        check({tag, "_done_busy"}, busy, 1);
        check({tag, "_done_wj"}, {w, j}, 0);
        @(negedge clk);
        check({tag, "_valid_pulse"}, valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_hold_min"}, min_cost, vecs[idx].mn);
    endtask

    int lat;
    logic [COST_W-1:0] m3 [4][4];
    int wexp [12];
    int jexp [12];

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        m3 = '{'{7'd3, 7'd1, 7'd2, 7'd9}, '{7'd1, 7'd4, 7'd4, 7'd9},
               '{7'd2, 7'd5, 7'd1, 7'd9}, '{7'd9, 7'd9, 7'd9, 7'd0}};
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                cm[a][b]           = 7'd0;
                vecs[0].c[a*4+b]   = (a == b) ? 7'd0 : 7'd10;
                vecs[1].c[a*4+b]   = 7'd5;
                vecs[2].c[a*4+b]   = m3[a][b];
                vecs[3].c[a*4+b]   = (((a + b) % 2) == 1) ? 7'd0 : 7'd7;
                vecs[4].c[a*4+b]   = 7'd127;
                vecs[5].c[a*4+b]   = ((a + b) == 3) ? 7'd0 : 7'd9;
            end
        end
        vecs[0].mn = 10'd0;   vecs[0].cnt = 4'd1;  vecs[0].best = 8'hE4;
        vecs[1].mn = 10'd20;  vecs[1].cnt = 4'd15; vecs[1].best = 8'hE4;
        vecs[2].mn = 10'd3;   vecs[2].cnt = 4'd1;  vecs[2].best = 8'hE1;
        vecs[3].mn = 10'd0;   vecs[3].cnt = 4'd4;  vecs[3].best = 8'hB1;
        vecs[4].mn = 10'd508; vecs[4].cnt = 4'd15; vecs[4].best = 8'hE4;
        vecs[5].mn = 10'd0;   vecs[5].cnt = 4'd1;  vecs[5].best = 8'h1B;
        wexp = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        jexp = '{0, 1, 2, 3, 0, 1, 3, 2, 0, 2, 1, 3};

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_wj", {w, j}, 0);
        check("rst_min", min_cost, 10'h3FF);
        check("rst_cnt", match_count, 0);
        check("rst_best", best_perm, 8'hE4);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            load(v);
            do_run(lat);
            check_result($sformatf("vec%0d", v), v, lat);
        end

        // First three permutations as seen on the cost-table address.
        load(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("seq_busy", busy, 1);
        for (int c = 0; c < 12; c++) begin
            check($sformatf("seq_w%0d", c), w, wexp[c]);
            check($sformatf("seq_j%0d", c), j, jexp[c]);
            @(negedge clk);
        end
        lat = 13;
        wait_valid(lat);
        check_lat("seq_lat", lat);
        @(negedge clk);

        // Reset part-way through a run, then a clean rerun.
        load(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_min", min_cost, 10'h3FF);
        check("mid_rst_cnt", match_count, 0);
        check("mid_rst_best", best_perm, 8'hE4);
        check("mid_rst_wj", {w, j}, 0);
        do_run(lat);
        check_result("after_rst", 2, lat);

        // Start held high across a whole run and into the following idle cycle.
        load(5);
        start = 1'b1;
        @(negedge clk);
        lat = 1;
        wait_valid(lat);
        check_lat("held_lat", lat);
        @(negedge clk);
        check("held_valid_low", valid, 0);
        check("held_idle_busy", busy, 0);
        check("held_hold_min", min_cost, 10'd0);
        check("held_hold_best", best_perm, 8'h1B);
        @(negedge clk);
        start = 1'b0;
        check("held_restart_busy", busy, 1);
        check("held_restart_min", min_cost, 10'h3FF);
        check("held_restart_cnt", match_count, 0);
        check("held_restart_valid", valid, 0);
        lat = 1;
        wait_valid(lat);
        check_result("held_second", 5, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
